vga_layer_compositor: RTL

//  Parametrised VGA timing generator plus N-layer sprite compositor; successor to the fixed 640x480 top.

---
 rtl/vga_layer_compositor.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : vga_layer_compositor
// Description : Parametrised VGA timing generator with an N-layer fixed
//               priority RGB332 compositor and frame-synchronous,
//               double-buffered per-layer position registers.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_layer_compositor #(
  parameter int          CLK_DIV    = 4,
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          NUM_LAYERS = 4,
  parameter logic [7:0]  BG_COLOR   = 8'hFF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_LAYERS-1:0]   layer_data,
  input  logic [8*NUM_LAYERS-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]   layer_en,
  input  logic                    pos_wr_valid,
  output logic                    pos_wr_ready,
  input  logic [2:0]              pos_wr_layer,
  input  logic [9:0]              pos_wr_x,
  input  logic [9:0]              pos_wr_y,
  output logic [10*NUM_LAYERS-1:0] pos_x,
  output logic [10*NUM_LAYERS-1:0] pos_y,
  output logic                    pix_en,
  output logic [9:0]              hcount,
  output logic [9:0]              vcount,
  output logic                    frame_start,
  output logic [2:0]              red,
  output logic [2:0]              green,
  output logic [1:0]              blue,
  output logic                    hsync,
  output logic                    vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST       = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST         = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST         = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_ACT          = 10'(H_ACTIVE);
  localparam logic [9:0]       V_ACT          = 10'(V_ACTIVE);
  localparam logic [9:0]       V_ACT_LAST     = 10'(V_ACTIVE - 1);
  localparam logic [9:0]       H_SYNC_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       H_SYNC_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]       V_SYNC_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       V_SYNC_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [9:0]          hcount_q, hcount_d;
  logic [9:0]          vcount_q, vcount_d;
  logic [7:0]          rgb_q, rgb_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic [9:0]          pend_x_q [NUM_LAYERS];
  logic [9:0]          pend_x_d [NUM_LAYERS];
  logic [9:0]          pend_y_q [NUM_LAYERS];
  logic [9:0]          pend_y_d [NUM_LAYERS];
  logic [9:0]          pos_x_q  [NUM_LAYERS];
  logic [9:0]          pos_x_d  [NUM_LAYERS];
  logic [9:0]          pos_y_q  [NUM_LAYERS];
  logic [9:0]          pos_y_d  [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] dirty_q, dirty_d;

  logic                pix_en_w;
  logic                active_w;
  logic                hit_any_w;
  logic [7:0]          hit_rgb_w;

  assign pix_en_w = (div_q == DIV_LAST);
  assign active_w = (hcount_q < H_ACT) && (vcount_q < V_ACT);

  // Fixed-priority layer select: scanning downward lets the lowest index win.
  always_comb begin
    hit_any_w = 1'b0;
    hit_rgb_w = 8'h00;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_data[i] && layer_en[i]) begin
        hit_any_w = 1'b1;
        hit_rgb_w = layer_rgb[8*i +: 8];
      end
    end
  end

  // Pixel divider, raster counters, and syncs/colour taken from pre-update counters.
  always_comb begin
    div_d    = pix_en_w ? '0 : div_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    rgb_d    = rgb_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    if (pix_en_w) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
      hsync_d = !((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END));
      vsync_d = !((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END));
      rgb_d   = active_w ? (hit_any_w ? hit_rgb_w : BG_COLOR) : 8'h00;
    end
  end

  // Position buffering: writes collect in pending slots, copied out in the single COMMIT clock.
  always_comb begin
    state_d  = state_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    dirty_d  = dirty_q;
    case (state_q)
      ST_RUN: begin
        // Out-of-range layer indices match no slot, so the handshake completes with no effect.
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (pos_wr_valid && (pos_wr_layer == 3'(i))) begin
            pend_x_d[i] = pos_wr_x;
            pend_y_d[i] = pos_wr_y;
            dirty_d[i]  = 1'b1;
          end
        end
        if (pix_en_w && (hcount_q == H_LAST) && (vcount_q == V_ACT_LAST)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (dirty_q[i]) begin
            pos_x_d[i] = pend_x_q[i];
            pos_y_d[i] = pend_y_q[i];
          end
        end
        dirty_d = '0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_RUN;
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      rgb_q    <= 8'h00;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      pend_x_q <= '{default: '0};
      pend_y_q <= '{default: '0};
      pos_x_q  <= '{default: '0};
      pos_y_q  <= '{default: '0};
      dirty_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      dirty_q  <= dirty_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_pos_flat
      assign pos_x[10*g +: 10] = pos_x_q[g];
      assign pos_y[10*g +: 10] = pos_y_q[g];
    end
  endgenerate

  assign pos_wr_ready = (state_q == ST_RUN);
  assign frame_start  = (state_q == ST_COMMIT);
  assign pix_en       = pix_en_w;
  assign hcount       = hcount_q;
  assign vcount       = vcount_q;
  assign red          = rgb_q[7:5];
  assign green        = rgb_q[4:2];
  assign blue         = rgb_q[1:0];
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;

endmodule
`default_nettype wire
